qsn_sched: RTL

- Column scheduler for the quasi-cyclic shift network (QSN) in the LDPC datapath.
- Holds a programmable table of per-column circulant shifts and enable flags for one base-matrix row.
- On start, it walks the table in column order. Per column it takes one lifted input word through a valid/ready handshake, drives the external QSN with that word and the column's shift, and registers the rotated result toward the check-node stage with valid/ready.
- Disabled (null-circulant) columns still consume an input word but emit zero.

---
 rtl/qsn_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/qsn_sched.sv
// Column scheduler for the LDPC quasi-cyclic shift network: walks a per-row
// table of circulant shifts, feeds the external QSN and registers its result.
module qsn_sched #(
   parameter int unsigned LiftingFactor = 4,
   parameter int unsigned ShiftWidth    = 2,
   parameter int unsigned MaxCols       = 8,
   parameter int unsigned ColWidth      = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [ColWidth-1:0]      cfg_addr,
   input  logic [ShiftWidth-1:0]    cfg_shift,
   input  logic                     cfg_en,
   input  logic [ColWidth:0]        num_cols,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LiftingFactor-1:0] in_data,
   output logic [LiftingFactor-1:0] qsn_in,
   output logic [ShiftWidth-1:0]    qsn_shift,
   input  logic [LiftingFactor-1:0] qsn_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LiftingFactor-1:0] out_data,
   output logic [ColWidth-1:0]      out_col
);

   localparam int unsigned CntW = ColWidth + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                   r_state;
   logic [ShiftWidth-1:0]    r_shift [MaxCols];
   logic [MaxCols-1:0]       r_en;
   logic [ColWidth-1:0]      r_col;
   logic [CntW-1:0]          r_count;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_out_valid;
   logic [LiftingFactor-1:0] r_out_data;
   logic [ColWidth-1:0]      r_out_col;

   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_last;
   logic [CntW-1:0]          w_num_cols;

   // in_ready depends only on registered state and out_ready, never on in_valid
   assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_last     = ({1'b0, r_col} == (r_count - CntW'(1)));
   assign w_num_cols = (num_cols > CntW'(MaxCols)) ? CntW'(MaxCols) : num_cols;

   assign busy      = r_busy;
   assign done      = r_done;
   assign in_ready  = w_in_ready;
   assign qsn_in    = in_data;
   assign qsn_shift = r_shift[r_col];
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_col   = r_out_col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         for (int i = 0; i < int'(MaxCols); i++) begin
            r_shift[i] <= '0;
         end
         r_en        <= '0;
         r_col       <= '0;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_col   <= '0;
      end else begin
         r_done <= 1'b0;

         // Table is only writable between passes
         if (cfg_we && (r_state == ST_IDLE)) begin
            r_shift[cfg_addr] <= cfg_shift;
            r_en[cfg_addr]    <= cfg_en;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (num_cols != '0) begin
                     r_count <= w_num_cols;
                     r_col   <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_out_data  <= r_en[r_col] ? qsn_out : '0;
                  r_out_col   <= r_col;
                  r_out_valid <= 1'b1;
                  if (w_last) begin
                     r_col   <= '0;
                     r_state <= ST_DRAIN;
                  end else begin
                     r_col <= r_col + ColWidth'(1);
                  end
               end else if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!r_out_valid || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
